// File: rtl/exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl_pkg
// Description : Shared constants for the exception/pipeline-control sequencer:
//               excepttype codes, stall encodings, Status/Cause bit positions,
//               MEM-stage request bit positions, FSM state type and the
//               priority encoder used to pick a single exception code.
// Revision    : 1.0 - initial release
// ============================================================================
package exc_ctrl_pkg;

    // excepttype codes handed to CP0
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // stall vector encodings, bit order {wb,mem,ex,id,if,pc}
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    // CP0 Status/Cause bit positions
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_LO      = 8;
    localparam int IM_HI      = 15;

    // mem_except_i bit positions: {eret,ov,trap,invalid,syscall}
    localparam int REQ_SYS  = 0;
    localparam int REQ_INV  = 1;
    localparam int REQ_TRAP = 2;
    localparam int REQ_OV   = 3;
    localparam int REQ_ERET = 4;

    // sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Fixed-priority selection of a single code; interrupts beat every
    // synchronous cause so at most one exception is ever issued per cycle.
    function automatic logic [31:0] exc_code(input logic       int_pend,
                                             input logic [4:0] req);
        logic [31:0] code;
        code = EXC_NONE;
        if (int_pend)           code = EXC_INT;
        else if (req[REQ_SYS])  code = EXC_SYS;
        else if (req[REQ_INV])  code = EXC_INV;
        else if (req[REQ_TRAP]) code = EXC_TRAP;
        else if (req[REQ_OV])   code = EXC_OV;
        else if (req[REQ_ERET]) code = EXC_ERET;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl_if
// Description : Bundle of the MEM-stage, CP0 and pipeline-control signals seen
//               by the exception sequencer. The slave side is the sequencer;
//               the master side is the surrounding pipeline/CP0.
// Revision    : 1.0 - initial release
// ============================================================================
interface exc_ctrl_if;

    logic [5:0]  int_i;
    logic [5:0]  int_sync_o;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic [4:0]  mem_except_i;
    logic [31:0] mem_pc_i;
    logic        mem_dslot_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_dslot_o;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output int_i, stallreq_id_i, stallreq_ex_i, mem_except_i, mem_pc_i,
               mem_dslot_i, status_i, cause_i, epc_i,
        input  int_sync_o, excepttype_o, exc_pc_o, exc_dslot_o, stall_o,
               flush_o, new_pc_o
    );

    modport slave (
        input  int_i, stallreq_id_i, stallreq_ex_i, mem_except_i, mem_pc_i,
               mem_dslot_i, status_i, cause_i, epc_i,
        output int_sync_o, excepttype_o, exc_pc_o, exc_dslot_o, stall_o,
               flush_o, new_pc_o
    );

endinterface
`default_nettype wire

// File: rtl/exc_ctrl_int_sync.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl_int_sync
// Description : Multi-flop synchroniser for the raw external interrupt lines.
//               Output is the input delayed by STAGES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl_int_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // shift chain: element 0 captures the raw lines, the top element is output
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Pipeline-control and exception sequencer for CP0. Picks one
//               exception per cycle from MEM-stage requests and pending
//               interrupts, flushes the pipeline with zero latency, supplies
//               the redirect PC and then ignores new exceptions for a short
//               drain window. Also drives the stall vector and synchronises
//               the external interrupt lines for CP0.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      rst,
    exc_ctrl_if.slave bus
);

    // drain counter reload value: counting down to zero spans DRAIN_CYCLES
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [2:0]  drain_cnt;
    logic [2:0]  next_cnt;
    logic        int_pend;
    logic [31:0] code;
    logic        flush;
    logic [5:0]  stall;
    logic        unused_bits;

    exc_ctrl_int_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (6)
    ) u_int_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.int_i),
        .dout (bus.int_sync_o)
    );

    // interrupt is taken only with IE set, EXL clear and an unmasked pending line
    assign int_pend = bus.status_i[STATUS_IE] & ~bus.status_i[STATUS_EXL] &
                      (|(bus.cause_i[IM_HI:IM_LO] & bus.status_i[IM_HI:IM_LO]));

    // status/cause fields that have no influence on sequencing
    assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                           bus.cause_i[31:16], bus.cause_i[7:0]};

    // state register and drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= 3'd0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_cnt;
        end
    end

    // exception decode (IDLE with a real instruction in MEM) and next state
    always_comb begin
        next_state = state;
        next_cnt   = drain_cnt;
        code       = EXC_NONE;
        case (state)
            ST_IDLE: begin
                // a bubble defers any pending interrupt to the next real instruction
                if (bus.mem_pc_i != 32'd0) begin
                    code = exc_code(int_pend, bus.mem_except_i);
                end
                if (code != EXC_NONE) begin
                    next_state = ST_DRAIN;
                    next_cnt   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 3'd0) begin
                    next_state = ST_IDLE;
                end else begin
                    next_cnt = drain_cnt - 3'd1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = 3'd0;
            end
        endcase
    end

    assign flush = (code != EXC_NONE);

    // stall vector: an exception overrides any stall request
    always_comb begin
        stall = STALL_NONE;
        if (!flush) begin
            if (bus.stallreq_ex_i)      stall = STALL_EX;
            else if (bus.stallreq_id_i) stall = STALL_ID;
        end
    end

    // all combinational outputs are held at zero while reset is asserted
    assign bus.excepttype_o = rst ? EXC_NONE : code;
    assign bus.flush_o      = rst ? 1'b0 : flush;
    assign bus.stall_o      = rst ? STALL_NONE : stall;
    assign bus.new_pc_o     = (rst || !flush) ? 32'd0 :
                              (code == EXC_ERET) ? bus.epc_i : EXC_VECTOR;
    assign bus.exc_pc_o     = rst ? 32'd0 : bus.mem_pc_i;
    assign bus.exc_dslot_o  = rst ? 1'b0 : bus.mem_dslot_i;

endmodule
`default_nettype wire
